trunc_sat: RTL and testbench
============================

# trunc_sat

Pipelined narrowing unit: takes a WIDTH_I-bit value and returns its low WIDTH_O bits. It checks whether the value is representable in the narrower width, as signed or unsigned, and can saturate on overflow. It sits on the CPU store/writeback path wherever a 64-bit register value is narrowed to a word, half or byte. It uses valid/ready handshakes on both sides and keeps a saturating overflow counter for debug.

## Interface
Parameters:
- WIDTH_I, 64, input width.
- WIDTH_O, 32, output width. Legal range 2 ≤ WIDTH_O < WIDTH_I.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high.
- in_valid  input  1  upstream holds a value.
- in_ready  output  1  block accepts on this edge if in_valid.
- value  input  WIDTH_I  data to narrow.
- signex  input  1  1: signed range check and saturation; 0: unsigned.
- sat  input  1  1: saturate on overflow; 0: plain truncation.
- out_valid  output  1  result/ovf valid.
- out_ready  input  1  downstream accepts.
- result  output  WIDTH_O  narrowed value.
- ovf  output  1  value not representable in WIDTH_O under signex.
- ovf_count  output  8  saturating count of delivered results with ovf=1.

## Operation
- Overflow rule:
  - signex=1: ovf = bits [WIDTH_I-1:WIDTH_O-1] of value are not all equal.
  - signex=0: ovf = any bit of [WIDTH_I-1:WIDTH_O] is set.
- Result rule:
  - If ovf=0 or sat=0: result = value[WIDTH_O-1:0].
  - If ovf=1, sat=1, signex=1: value MSB 0 gives 0 followed by all 1s (max positive); MSB 1 gives 1 followed by all 0s (min negative).
  - If ovf=1, sat=1, signex=0: result = all 1s.
- Pipeline stages:
  - S1 registers value, signex, sat and computes ovf plus the saturated candidate.
  - S2 is the output register that drives result, ovf and out_valid.
- Stage advance rules:
  - S2 loads when it is empty or out_ready=1.
  - S1 advances when S2 loads.
  - in_ready = !S1_valid || S2 loads.
- Ordering and backpressure: strict in-order delivery with no drops or duplicates. At most 2 items in flight.
- ovf_count: increments on each output handshake (out_valid && out_ready) with ovf=1, and holds at 255.

## Timing
- Reset values: out_valid=0, result=0, ovf=0, ovf_count=0, S1 empty. in_ready is 1 as soon as reset is released.
- Latency: an input accepted at the edge ending cycle n appears on the outputs in cycle n+2.
- Throughput: 1 result per cycle while out_ready=1.
- Output hold: while out_valid=1 and out_ready=0, result and ovf hold stable.
- in_ready is combinational from out_ready; there is no combinational path from in_* to out_*.
- Simultaneous events:
  - Output handshake and input accept on the same edge: both occur; S1 moves to S2, the new input enters S1.
  - Pipeline full with out_ready=0: in_ready=0.
- Reset mid-operation: both stages clear immediately (asynchronously), in-flight items are discarded, and ovf_count returns to 0.
- Boundary values:
  - Signed: value = 2^(WIDTH_O-1)-1 and value = -2^(WIDTH_O-1) give ovf=0.
  - Unsigned: value = 2^WIDTH_O - 1 gives ovf=0.

## Structure
- Width constants DWORD=64, WORD=32, HALF=16, BYTE=8 go in the shared package cpu_widths_pkg; instances select from these.
- One combinational sub-module, range_check #(WIDTH_I, WIDTH_O), with inputs value and signex and outputs ovf, sat_value. S1 instantiates it.
- Handshake and stage registers stay in trunc_sat.

## Test plan
All scenarios use WIDTH_I=64, WIDTH_O=8.
1. Signed in range: value=0xFFFF_FFFF_FFFF_FF80, signex=1, sat=1 → result=0x80, ovf=0, out_valid in cycle n+2.
2. Signed saturation: value=0x80 → result=0x7F, ovf=1. Then value=0xFFFF_FFFF_FFFF_FF7F → result=0x80, ovf=1. Then value=0x7F → 0x7F, ovf=0.
3. Unsigned: signex=0.
   - value=0x1FF, sat=0 → 0xFF, ovf=1.
   - value=0x100, sat=0 → 0x00, ovf=1.
   - value=0x100, sat=1 → 0xFF, ovf=1.
   - value=0xFF → 0xFF, ovf=0.
4. Backpressure: stream values 1, 2, 3, 4 with out_ready=0.
   - in_ready must drop after 2 accepts.
   - result must hold 0x01.
   - Raise out_ready: outputs 1, 2, 3, 4 in order on consecutive cycles.
5. Reset mid-flight: 2 items in flight, assert reset between edges → out_valid=0 and ovf_count=0 immediately. After release, the first new input is delivered 2 cycles after it is accepted.
6. Counter saturation: deliver 300 overflowing results → ovf_count=255. Results with ovf=0 and cycles with out_ready=0 do not increment it.

Source files
------------

// File: rtl/cpu_widths_pkg.sv
// cpu_widths_pkg: register and memory access widths shared across the CPU datapath.
package cpu_widths_pkg;
   localparam int DWORD = 64;
   localparam int WORD  = 32;
   localparam int HALF  = 16;
   localparam int BYTE  = 8;
endpackage

// File: rtl/trunc_sat_range_check.sv
// range_check: representability check of a wide value in WIDTH_O bits and its saturated narrowing.
module range_check #(
   parameter int WIDTH_I = 64,
   parameter int WIDTH_O = 32
) (
   input  logic [WIDTH_I-1:0] value,
   input  logic               signex,
   output logic               ovf,
   output logic [WIDTH_O-1:0] sat_value
);
   logic [WIDTH_I-WIDTH_O:0] shi;
   logic [WIDTH_I-WIDTH_O-1:0] uhi;
   logic [WIDTH_O-1:0] clamp;
   assign shi = value[WIDTH_I-1:WIDTH_O-1];
   assign uhi = value[WIDTH_I-1:WIDTH_O];
   always_comb begin
      ovf = signex ? !((&shi) || !(|shi)) : |uhi;
      clamp = signex ? {value[WIDTH_I-1], {(WIDTH_O-1){~value[WIDTH_I-1]}}} : '1;
      sat_value = ovf ? clamp : value[WIDTH_O-1:0];
   end
endmodule

// File: rtl/trunc_sat.sv
// trunc_sat: two-stage valid/ready narrowing unit with optional saturation and an overflow counter.
module trunc_sat
   import cpu_widths_pkg::*;
#(
   parameter int WIDTH_I = DWORD,
   parameter int WIDTH_O = WORD
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH_I-1:0] value,
   input  logic               signex,
   input  logic               sat,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH_O-1:0] result,
   output logic               ovf,
   output logic [7:0]         ovf_count
);
   logic               s1_valid, s1_signex, s1_sat, s1_ovf, s2_load;
   logic [WIDTH_I-1:0] s1_value;
   logic [WIDTH_O-1:0] s1_satv;
   assign s2_load  = !out_valid || out_ready;
   assign in_ready = !s1_valid || s2_load;
   range_check #(.WIDTH_I(WIDTH_I), .WIDTH_O(WIDTH_O)) u_rc (
      .value(s1_value),
      .signex(s1_signex),
      .ovf(s1_ovf),
      .sat_value(s1_satv)
   );
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         s1_valid  <= 1'b0;
         s1_value  <= '0;
         s1_signex <= 1'b0;
         s1_sat    <= 1'b0;
         out_valid <= 1'b0;
         result    <= '0;
         ovf       <= 1'b0;
         ovf_count <= '0;
      end else begin
         if (in_valid && in_ready) begin
            s1_valid  <= 1'b1;
            s1_value  <= value;
            s1_signex <= signex;
            s1_sat    <= sat;
         end else if (s2_load) s1_valid <= 1'b0;
         if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
               result <= s1_sat ? s1_satv : s1_value[WIDTH_O-1:0];
               ovf    <= s1_ovf;
            end
         end
         // counts delivered overflows only, sticking at the top
         if (out_valid && out_ready && ovf && ovf_count != 8'hFF) ovf_count <= ovf_count + 8'd1;
      end
endmodule

// File: tb/tb_trunc_sat.sv
// tb_trunc_sat: directed stimulus with a queue scoreboard for trunc_sat at 64->8 bits.
module tb_trunc_sat;
   logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0, in_ready, signex = 1'b0, sat = 1'b0;
   logic        out_valid, out_ready = 1'b0, ovf;
   logic [63:0] value = '0;
   logic [7:0]  result, ovf_count, mcount = '0, prev_res = '0;
   logic        prev_hold = 1'b0;
   logic [8:0]  q[$];
   logic [8:0]  e;
   int          checks = 0, errors = 0;
   trunc_sat #(.WIDTH_I(64), .WIDTH_O(8)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .value(value),
      .signex(signex), .sat(sat), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .ovf(ovf), .ovf_count(ovf_count)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   function automatic logic [8:0] model(input logic [63:0] v, input logic sx, input logic st);
      logic o;
      logic [7:0] r;
      o = sx ? !((&v[63:7]) || !(|v[63:7])) : |v[63:8];
      r = v[7:0];
      if (o && st) r = sx ? (v[63] ? 8'h80 : 8'h7F) : 8'hFF;
      return {o, r};
   endfunction
   // samples 1ns before each rising edge; inputs only change on falling edges
   always begin
      @(negedge clk);
      #4;
      if (!reset) begin
         chk("ovf_count", ovf_count, mcount);
         if (prev_hold) chk("hold", result, prev_res);
         if (out_valid && out_ready) begin
            if (q.size() == 0) chk("unexpected_output", 1, 0);
            else begin
               e = q.pop_front();
               chk("result", result, e[7:0]);
               chk("ovf", ovf, e[8]);
               if (e[8] && mcount != 8'hFF) mcount = mcount + 8'd1;
            end
         end
         if (in_valid && in_ready) q.push_back(model(value, signex, sat));
         prev_hold = out_valid && !out_ready;
         prev_res = result;
      end
   end
   task automatic send(input logic [63:0] v, input logic sx, input logic st);
      int n = 0;
      @(negedge clk);
      in_valid = 1'b1; value = v; signex = sx; sat = st;
      #4;
      while (!in_ready && n < 50) begin @(negedge clk); #4; n++; end
      chk("accept_timeout", in_ready, 1);
      @(posedge clk);
   endtask
   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask
   task automatic drain();
      int n = 0;
      while ((q.size() != 0 || out_valid) && n < 100) begin @(negedge clk); #4; n++; end
      chk("drain_timeout", q.size(), 0);
   endtask
   task automatic latency(input logic [63:0] v, input logic [7:0] r, input logic o);
      send(v, 1'b1, 1'b1);
      idle();
      #4 chk("lat_n1_valid", out_valid, 0);
      @(negedge clk);
      #4 chk("lat_n2_valid", out_valid, 1);
      chk("lat_result", result, r);
      chk("lat_ovf", ovf, o);
   endtask
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   initial begin
      repeat (2) @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      reset = 1'b0;
      #1 chk("rst_in_ready", in_ready, 1);
      chk("rst_result", result, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_count", ovf_count, 0);
      out_ready = 1'b1;
      latency(64'hFFFF_FFFF_FFFF_FF80, 8'h80, 1'b0);
      send(64'h80, 1'b1, 1'b1);
      send(64'hFFFF_FFFF_FFFF_FF7F, 1'b1, 1'b1);
      send(64'h7F, 1'b1, 1'b1);
      send(64'h1FF, 1'b0, 1'b0);
      send(64'h100, 1'b0, 1'b0);
      send(64'h100, 1'b0, 1'b1);
      send(64'hFF, 1'b0, 1'b1);
      idle();
      drain();
      chk("count_after_sets", ovf_count, 5);
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; value = 64'd1; signex = 1'b0; sat = 1'b0;
      #4 chk("bp_rdy1", in_ready, 1);
      @(negedge clk);
      value = 64'd2;
      #4 chk("bp_rdy2", in_ready, 1);
      @(negedge clk);
      value = 64'd3;
      for (int i = 0; i < 3; i++) begin
         #4 chk("bp_full_rdy", in_ready, 0);
         chk("bp_hold_valid", out_valid, 1);
         chk("bp_hold_result", result, 1);
         @(negedge clk);
      end
      out_ready = 1'b1;
      #4 chk("bp_out1", result, 1);
      @(negedge clk);
      value = 64'd4;
      #4 chk("bp_out2", result, 2);
      @(negedge clk);
      in_valid = 1'b0;
      #4 chk("bp_out3", result, 3);
      @(negedge clk);
      #4 chk("bp_out4", result, 4);
      chk("bp_out4_valid", out_valid, 1);
      drain();
      out_ready = 1'b0;
      send(64'h80, 1'b1, 1'b1);
      send(64'h81, 1'b1, 1'b1);
      idle();
      #2 reset = 1'b1;
      #1 chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_count", ovf_count, 0);
      q.delete();
      mcount = '0;
      prev_hold = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      out_ready = 1'b1;
      latency(64'h7F, 8'h7F, 1'b0);
      drain();
      out_ready = 1'b0;
      send(64'h100, 1'b0, 1'b1);
      idle();
      repeat (4) @(negedge clk);
      #4 chk("stall_count", ovf_count, 0);
      @(negedge clk);
      out_ready = 1'b1;
      drain();
      chk("one_count", ovf_count, 1);
      for (int i = 0; i < 300; i++) send(64'h100 + 64'(i), 1'b0, 1'b1);
      send(64'h12, 1'b0, 1'b1);
      idle();
      drain();
      chk("sat_count", ovf_count, 255);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
